dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer for the byte-addressed, big-endian 32-bit data memory.

---
 rtl/dmem_arbiter_if.sv | 26 ++
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request ports sharing one ack/err/rdata return.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [31:0] addr0;
   logic [31:0] addr1;
   logic [31:0] wdata0;
   logic [31:0] wdata1;
   logic        ack0;
   logic        ack1;
   logic        err;
   logic [31:0] rdata;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  ack0, ack1, err, rdata
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output ack0, ack1, err, rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 32-bit data memory: alignment/range check,
// single-cycle write strobe, READ_WAIT-cycle read settle and a one-cycle ack to the winner.
module dmem_arbiter #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned READ_WAIT = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   dmem_arbiter_if.slave bus,
   output logic [31:0]   mem_address,
   output logic [31:0]   mem_writedata,
   output logic          mem_we,
   input  logic [31:0]   mem_data
);

   localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 32'd4);
   localparam logic [3:0]  CNT_INIT = 4'(READ_WAIT - 32'd1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        we_q, we_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_writedata_q, mem_writedata_d;

   logic        sel_s;
   logic        sel_we_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic        bad_addr_s;

   // Winner selection: under contention the port that did not win last time gets the grant.
   always_comb begin
      sel_s = 1'b0;
      if (bus.req0 && bus.req1) begin
         sel_s = ~last_grant_q;
      end else begin
         sel_s = bus.req1;
      end
      sel_we_s    = sel_s ? bus.we1    : bus.we0;
      sel_addr_s  = sel_s ? bus.addr1  : bus.addr0;
      sel_wdata_s = sel_s ? bus.wdata1 : bus.wdata0;
      bad_addr_s  = (sel_addr_s[1:0] != 2'b00) || (sel_addr_s > MAX_ADDR);
   end

   // Next-state and registered-output computation for the IDLE/ACCESS/DONE sequencer.
   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      we_d            = we_q;
      cnt_d           = cnt_q;
      ack0_d          = ack0_q;
      ack1_d          = ack1_q;
      err_d           = err_q;
      rdata_d         = rdata_q;
      mem_we_d        = mem_we_q;
      mem_address_d   = mem_address_q;
      mem_writedata_d = mem_writedata_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req0 || bus.req1) begin
               last_grant_d = sel_s;
               we_d         = sel_we_s;
               if (bad_addr_s) begin
                  // Rejected accesses never touch the memory; ack straight away.
                  err_d   = 1'b1;
                  ack0_d  = ~sel_s;
                  ack1_d  = sel_s;
                  state_d = S_DONE;
               end else begin
                  mem_address_d   = sel_addr_s;
                  mem_writedata_d = sel_wdata_s;
                  if (sel_we_s) begin
                     mem_we_d = 1'b1;
                     cnt_d    = 4'd0;
                  end else begin
                     mem_we_d = 1'b0;
                     cnt_d    = CNT_INIT;
                  end
                  state_d = S_ACCESS;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ACCESS: begin
            if (we_q) begin
               mem_we_d = 1'b0;
               ack0_d   = ~last_grant_q;
               ack1_d   = last_grant_q;
               state_d  = S_DONE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rdata_d = mem_data;
               ack0_d  = ~last_grant_q;
               ack1_d  = last_grant_q;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            ack0_d   = 1'b0;
            ack1_d   = 1'b0;
            err_d    = 1'b0;
            mem_we_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         last_grant_q    <= 1'b1;
         we_q            <= 1'b0;
         cnt_q           <= 4'd0;
         ack0_q          <= 1'b0;
         ack1_q          <= 1'b0;
         err_q           <= 1'b0;
         rdata_q         <= 32'd0;
         mem_we_q        <= 1'b0;
         mem_address_q   <= 32'd0;
         mem_writedata_q <= 32'd0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         we_q            <= we_d;
         cnt_q           <= cnt_d;
         ack0_q          <= ack0_d;
         ack1_q          <= ack1_d;
         err_q           <= err_d;
         rdata_q         <= rdata_d;
         mem_we_q        <= mem_we_d;
         mem_address_q   <= mem_address_d;
         mem_writedata_q <= mem_writedata_d;
      end
   end

   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign mem_we        = mem_we_q;
   assign mem_address   = mem_address_q;
   assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: READ_WAIT=1 instance with a word memory model, plus a
// READ_WAIT=4 instance reading a fixed pattern memory.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          ack_total = 0;
   int          we_cycles = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter_if bus ();
   dmem_arbiter_if bus4 ();

   logic [31:0] mem_address, mem_writedata, mem_data;
   logic        mem_we;
   logic [31:0] mem_address4, mem_writedata4, mem_data4;
   logic        mem_we4;

   dmem_arbiter #(.MEM_BYTES(1024), .READ_WAIT(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave),
      .mem_address(mem_address), .mem_writedata(mem_writedata),
      .mem_we(mem_we), .mem_data(mem_data)
   );

   dmem_arbiter #(.MEM_BYTES(1024), .READ_WAIT(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .bus(bus4.slave),
      .mem_address(mem_address4), .mem_writedata(mem_writedata4),
      .mem_we(mem_we4), .mem_data(mem_data4)
   );

   // Word memory for the main instance; filled with a pattern on the first clock.
   logic [31:0] mem [0:255];
   bit          mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
         mem_ready <= 1'b1;
      end else if (mem_we) begin
         mem[mem_address[9:2]] <= mem_writedata;
      end
   end
   assign mem_data  = mem[mem_address[9:2]];
   assign mem_data4 = 32'h1000_0000 + {24'd0, mem_address4[9:2]};

   always @(negedge clk) if (mem_we) we_cycles <= we_cycles + 1;

   typedef struct {
      int          port;
      logic        err;
      logic        chk_rd;
      logic [31:0] rd;
      int          exp_cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q4[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int inst, input int port, input logic err, input logic chk_rd,
                           input logic [31:0] rd, input int exp_cyc);
      exp_t e;
      e.port = port; e.err = err; e.chk_rd = chk_rd; e.rd = rd; e.exp_cyc = exp_cyc;
      if (inst == 0) q0.push_back(e);
      else q4.push_back(e);
   endtask

   task automatic check_ack(input int inst, input int port, input logic err, input logic [31:0] rd);
      exp_t e;
      ack_total++;
      if ((inst == 0 && q0.size() == 0) || (inst != 0 && q4.size() == 0)) begin
         checks++;
         failures++;
         $display("FAIL unexpected_ack inst=%0d port=%0d cycle=%0d required=none", inst, port, cyc);
      end else begin
         if (inst == 0) e = q0.pop_front();
         else e = q4.pop_front();
         chk("ack_port", 32'(port), 32'(e.port));
         chk("ack_err", {31'd0, err}, {31'd0, e.err});
         if (e.chk_rd) chk("ack_rdata", rd, e.rd);
         if (e.exp_cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(e.exp_cyc));
      end
   endtask

   // Monitor: compare every ack against the head of the expectation queue.
   always @(negedge clk) begin
      if (bus.ack0 && bus.ack1) begin
         checks++; failures++;
         $display("FAIL both_acks inst=0 actual=11 required=one");
      end else if (bus.ack0) check_ack(0, 0, bus.err, bus.rdata);
      else if (bus.ack1) check_ack(0, 1, bus.err, bus.rdata);
      if (bus4.ack0 && bus4.ack1) begin
         checks++; failures++;
         $display("FAIL both_acks inst=4 actual=11 required=one");
      end else if (bus4.ack0) check_ack(4, 0, bus4.err, bus4.rdata);
      else if (bus4.ack1) check_ack(4, 1, bus4.err, bus4.rdata);
   end

   task automatic drive(input int inst, input int port, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (inst == 0) begin
         if (port == 0) begin bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; end
         else begin bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; end
      end else begin
         if (port == 0) begin bus4.req0 = req; bus4.we0 = we; bus4.addr0 = addr; bus4.wdata0 = wdata; end
         else begin bus4.req1 = req; bus4.we1 = we; bus4.addr1 = addr; bus4.wdata1 = wdata; end
      end
   endtask

   function automatic logic get_ack(input int inst, input int port);
      if (inst == 0) return (port == 0) ? bus.ack0 : bus.ack1;
      else return (port == 0) ? bus4.ack0 : bus4.ack1;
   endfunction

   // One request: optionally queue the expectation, hold req until ack, drop it on the ack edge.
   task automatic do_req(input int inst, input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input logic exp_err,
                         input logic chk_rd, input logic [31:0] exp_rd, input bit push);
      bit got = 1'b0;
      int n = 0;
      if (push) push_exp(inst, port, exp_err, chk_rd, exp_rd, (lat > 0) ? cyc + lat : -1);
      drive(inst, port, 1'b1, we, addr, wdata);
      while (!got && n < 64) begin
         @(negedge clk);
         n++;
         if (get_ack(inst, port)) got = 1'b1;
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL ack_timeout inst=%0d port=%0d addr=%h actual=none required=ack", inst, port, addr);
      end
      @(posedge clk);
      #1;
      drive(inst, port, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic reset_pulse();
      @(negedge clk) reset_n = 1'b0;
      @(negedge clk) reset_n = 1'b1;
   endtask

   initial begin : stim
      int base;
      reset_n = 1'b0;
      drive(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(4, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(4, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;

      chk("rst_ack0", {31'd0, bus.ack0}, 32'd0);
      chk("rst_ack1", {31'd0, bus.ack1}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_address", mem_address, 32'd0);
      chk("rst_mem_writedata", mem_writedata, 32'd0);

      // T1: reset in the middle of a read.
      drive(0, 0, 1'b1, 1'b0, 32'h20, 32'h0);
      @(posedge clk); #1;
      chk("t1_addr_in_access", mem_address, 32'h20);
      reset_n = 1'b0;
      #1;
      chk("t1_mem_address", mem_address, 32'd0);
      chk("t1_ack0", {31'd0, bus.ack0}, 32'd0);
      chk("t1_err", {31'd0, bus.err}, 32'd0);
      chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
      drive(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      base = ack_total;
      repeat (4) @(negedge clk);
      chk("t1_no_ack", 32'(ack_total), 32'(base));

      // T2: write then read back on port 0.
      base = we_cycles;
      do_req(0, 0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("t2_we_cycles", 32'(we_cycles - base), 32'd1);
      do_req(0, 0, 1'b0, 32'h10, 32'd0, 2, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);

      // Fresh reset so port 0 wins the first contention.
      reset_pulse();
      #1;
      chk("rst2_rdata", bus.rdata, 32'd0);

      // T3: both ports request continuously; grants alternate 0,1,0,1.
      push_exp(0, 0, 1'b0, 1'b0, 32'd0, -1);
      push_exp(0, 1, 1'b0, 1'b0, 32'd0, -1);
      push_exp(0, 0, 1'b0, 1'b1, 32'h2222_2222, -1);
      push_exp(0, 1, 1'b0, 1'b1, 32'h1111_1111, -1);
      fork
         begin
            do_req(0, 0, 1'b1, 32'h40, 32'h1111_1111, 0, 1'b0, 1'b0, 32'd0, 1'b0);
            do_req(0, 0, 1'b0, 32'h44, 32'd0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
         end
         begin
            do_req(0, 1, 1'b1, 32'h44, 32'h2222_2222, 0, 1'b0, 1'b0, 32'd0, 1'b0);
            do_req(0, 1, 1'b0, 32'h40, 32'd0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
         end
      join

      // T4: rejected accesses and the top-of-memory boundary.
      base = we_cycles;
      do_req(0, 1, 1'b0, 32'h13, 32'd0, 1, 1'b1, 1'b1, 32'h1111_1111, 1'b1);
      do_req(0, 0, 1'b1, 32'h2, 32'h5555_5555, 1, 1'b1, 1'b1, 32'h1111_1111, 1'b1);
      chk("t4_no_write_on_err", 32'(we_cycles - base), 32'd0);
      do_req(0, 0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 32'd0, 1'b1);
      do_req(0, 1, 1'b0, 32'h3FC, 32'd0, 2, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
      do_req(0, 1, 1'b0, 32'h400, 32'd0, 1, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1);

      // T5: READ_WAIT=4 instance holds the address for four cycles, ack after five edges.
      fork
         do_req(4, 0, 1'b0, 32'h8, 32'h1234_5678, 5, 1'b0, 1'b1, 32'h1000_0002, 1'b1);
         begin
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("t5_addr_stable", mem_address4, 32'h8);
               chk("t5_mem_we", {31'd0, mem_we4}, 32'd0);
            end
         end
      join
      chk("t5_writedata_passthru", mem_writedata4, 32'h1234_5678);

      // T6: port 1 reissues immediately after its ack.
      base = ack_total;
      do_req(0, 1, 1'b0, 32'h10, 32'd0, 2, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      do_req(0, 1, 1'b0, 32'h44, 32'd0, 2, 1'b0, 1'b1, 32'h2222_2222, 1'b1);
      repeat (6) @(negedge clk);
      chk("t6_ack_count", 32'(ack_total - base), 32'd2);

      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q4_drained", 32'(q4.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
